song_transport_ctrl: RTL and testbench



---
 rtl/song_transport_ctrl_if.sv | 22 ++
 rtl/song_transport_ctrl.sv | 140 ++++++++++++++
 tb/tb_song_transport_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/song_transport_ctrl_if.sv
// Transport controller signal bundle: button/song-reader inputs and timer control outputs.
interface song_transport_ctrl_if;
  logic       play_btn;
  logic       restart_btn;
  logic       song_end;
  logic       play;
  logic       reset_player;
  logic       song_done;
  logic       paused;
  logic [1:0] state;
  logic [7:0] elapsed_s;

  modport master (
    output play_btn, restart_btn, song_end,
    input  play, reset_player, song_done, paused, state, elapsed_s
  );

  modport slave (
    input  play_btn, restart_btn, song_end,
    output play, reset_player, song_done, paused, state, elapsed_s
  );
endinterface

// File: rtl/song_transport_ctrl.sv
// Playback transport FSM driving the song timer: play/pause/restart, elapsed seconds, timeout.
// Optional AUTO_REPEAT_EN: DONE immediately loops back to PLAYING with a timer clear.
module song_transport_ctrl #(
  parameter int unsigned CYCLES_PER_SEC = 100000000,
  parameter int unsigned CYC_WIDTH      = 27,
  parameter int unsigned MAX_SEC        = 99
) (
  input logic                 clk,
  input logic                 rst,
  song_transport_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CYC_WIDTH-1:0] CYC_LAST = CYC_WIDTH'(CYCLES_PER_SEC - 1);
  localparam logic [7:0]           SEC_LAST = 8'(MAX_SEC - 1);

  state_t               state_q, state_d;
  logic                 play_btn_q, restart_btn_q;
  logic                 play_press, restart_press;
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
  logic [7:0]           elapsed_q, elapsed_d;
  logic                 sec_wrap, timeout;
  logic                 play_q, paused_q, reset_player_q, song_done_q;
  logic                 reset_player_d, song_done_d;

  assign play_press    = bus.play_btn & ~play_btn_q;
  assign restart_press = bus.restart_btn & ~restart_btn_q;
  assign sec_wrap      = (state_q == PLAYING) && (cyc_q == CYC_LAST);
  assign timeout       = sec_wrap && (elapsed_q == SEC_LAST);

  always_comb begin
    state_d        = state_q;
    reset_player_d = 1'b0;
    cyc_d          = cyc_q;
    elapsed_d      = elapsed_q;

    // Time accrues on every PLAYING cycle, including the one that leaves PLAYING.
    if (state_q == PLAYING) begin
      if (sec_wrap) begin
        cyc_d     = '0;
        elapsed_d = elapsed_q + 8'd1;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (restart_press) begin
          reset_player_d = 1'b1;
        end else if (play_press) begin
          state_d        = PLAYING;
          reset_player_d = 1'b1;
        end
      end
      PLAYING: begin
        if (restart_press) begin
          reset_player_d = 1'b1;
        end else if (bus.song_end || timeout) begin
          state_d = DONE;
        end else if (play_press) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (restart_press) begin
          state_d        = IDLE;
          reset_player_d = 1'b1;
        end else if (bus.song_end) begin
          state_d = DONE;
        end else if (play_press) begin
          state_d = PLAYING;
        end
      end
      DONE: begin
        if (restart_press) begin
          state_d        = IDLE;
          reset_player_d = 1'b1;
`ifdef AUTO_REPEAT_EN
        end else begin
          state_d        = PLAYING;
          reset_player_d = 1'b1;
        end
`else
        end else if (play_press) begin
          state_d        = PLAYING;
          reset_player_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Every timer clear also restarts our own elapsed count; it overrides the advance above.
    if (reset_player_d) begin
      cyc_d     = '0;
      elapsed_d = '0;
    end

    song_done_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      play_btn_q     <= 1'b0;
      restart_btn_q  <= 1'b0;
      cyc_q          <= '0;
      elapsed_q      <= '0;
      play_q         <= 1'b0;
      paused_q       <= 1'b0;
      reset_player_q <= 1'b0;
      song_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      play_btn_q     <= bus.play_btn;
      restart_btn_q  <= bus.restart_btn;
      cyc_q          <= cyc_d;
      elapsed_q      <= elapsed_d;
      play_q         <= (state_d == PLAYING);
      paused_q       <= (state_d == PAUSED);
      reset_player_q <= reset_player_d;
      song_done_q    <= song_done_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.elapsed_s    = elapsed_q;
  assign bus.play         = play_q;
  assign bus.paused       = paused_q;
  assign bus.reset_player = reset_player_q;
  assign bus.song_done    = song_done_q;

endmodule

// File: tb/tb_song_transport_ctrl.sv
// Directed + random bench for song_transport_ctrl against a cycle-count reference model.
module tb_song_transport_ctrl;
  localparam int CPS  = 4;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  song_transport_ctrl_if bus ();

  song_transport_ctrl #(
    .CYCLES_PER_SEC(CPS),
    .CYC_WIDTH     (3),
    .MAX_SEC       (MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: state code, total PLAYING cycles since the last clear, previous button levels.
  int m_state = 0;
  int m_total = 0;
  bit m_pp    = 1'b0;
  bit m_pr    = 1'b0;
  bit m_rp    = 1'b0;
  bit m_sd    = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input int exp);
    logic [7:0] e;
    e = 8'(exp);
    assert (got === e) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit pb, input bit rb, input bit se);
    bit pp, pr, tmo;
    pp   = pb && !m_pp;
    pr   = rb && !m_pr;
    tmo  = 1'b0;
    m_rp = 1'b0;
    m_sd = 1'b0;
    if (r) begin
      m_state = 0;
      m_total = 0;
      m_pp    = 1'b0;
      m_pr    = 1'b0;
      return;
    end
    if (pr) begin
      m_rp    = 1'b1;
      m_total = 0;
      if (m_state != 1) m_state = 0;
    end else begin
      if (m_state == 1) begin
        m_total++;
        tmo = (m_total == MAXS * CPS);
      end
      case (m_state)
        0: if (pp) begin m_state = 1; m_rp = 1'b1; m_total = 0; end
        1: if (se || tmo) begin m_state = 3; m_sd = 1'b1; end
           else if (pp) m_state = 2;
        2: if (se) begin m_state = 3; m_sd = 1'b1; end
           else if (pp) m_state = 1;
        default: begin
`ifdef AUTO_REPEAT_EN
          m_state = 1; m_rp = 1'b1; m_total = 0;
`else
          if (pp) begin m_state = 1; m_rp = 1'b1; m_total = 0; end
`endif
        end
      endcase
    end
    m_pp = pb;
    m_pr = rb;
  endtask

  task automatic cyc(input bit r, input bit pb, input bit rb, input bit se);
    rst             = r;
    bus.play_btn    = pb;
    bus.restart_btn = rb;
    bus.song_end    = se;
    @(posedge clk);
    model_step(r, pb, rb, se);
    #1;
    n_vec++;
    chk("state",        {6'd0, bus.state},        m_state);
    chk("play",         {7'd0, bus.play},         int'(m_state == 1));
    chk("paused",       {7'd0, bus.paused},       int'(m_state == 2));
    chk("reset_player", {7'd0, bus.reset_player}, int'(m_rp));
    chk("song_done",    {7'd0, bus.song_done},    int'(m_sd));
    chk("elapsed_s",    bus.elapsed_s,            m_total / CPS);
  endtask

  initial begin
    bit pb, rb, se, r;

    // Reset, then idle with buttons low.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_state",   {6'd0, bus.state}, 0);
    chk("rst_elapsed", bus.elapsed_s, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);

    // Held play button: one press, then run to the max-duration timeout.
    for (int i = 0; i <= 12; i++) begin
      cyc(0, i < 10, 0, 0);
      if (i == 0) chk("press_pulse", {7'd0, bus.reset_player}, 1);
      if (i == 1) begin
        chk("press_once", {7'd0, bus.reset_player}, 0);
        chk("play_high",  {7'd0, bus.play}, 1);
      end
      if (i == 11) chk("elapsed_2", bus.elapsed_s, 2);
    end
    chk("timeout_elapsed", bus.elapsed_s, 3);
    chk("timeout_done",    {7'd0, bus.song_done}, 1);
    chk("timeout_play",    {7'd0, bus.play}, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

    // Pause/resume keeps the sub-second count.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    chk("paused_flag",    {7'd0, bus.paused}, 1);
    chk("paused_play",    {7'd0, bus.play}, 0);
    chk("paused_elapsed", bus.elapsed_s, 0);
    cyc(0, 1, 0, 0);
    chk("resume_elapsed0", bus.elapsed_s, 0);
    cyc(0, 0, 0, 0);
    chk("resume_elapsed1", bus.elapsed_s, 1);

    // Restart and song_end in the same cycle: restart wins.
    cyc(0, 0, 1, 1);
    chk("prio_state",   {6'd0, bus.state}, 1);
    chk("prio_rp",      {7'd0, bus.reset_player}, 1);
    chk("prio_sd",      {7'd0, bus.song_done}, 0);
    chk("prio_elapsed", bus.elapsed_s, 0);

    // Plain song_end from PLAYING.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("end_sd",    {7'd0, bus.song_done}, 1);
    chk("end_state", {6'd0, bus.state}, 3);
    cyc(0, 0, 0, 0);
`ifdef AUTO_REPEAT_EN
    chk("repeat_rp",      {7'd0, bus.reset_player}, 1);
    chk("repeat_play",    {7'd0, bus.play}, 1);
    chk("repeat_elapsed", bus.elapsed_s, 0);
`else
    chk("hold_state", {6'd0, bus.state}, 3);
    chk("hold_rp",    {7'd0, bus.reset_player}, 0);
`endif

    // Reset mid-playback.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("midrst_state", {6'd0, bus.state}, 0);
    chk("midrst_rp",    {7'd0, bus.reset_player}, 0);
    chk("midrst_el",    bus.elapsed_s, 0);

    // Random traffic.
    pb = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0)   pb = ~pb;
      if ($urandom_range(15) == 0)  rb = ~rb;
      se = ($urandom_range(19) == 0);
      r  = ($urandom_range(199) == 0);
      cyc(r, pb, rb, se);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
